byte_strobe_sdp_ram: RTL and testbench
======================================

BYTE_STROBE_SDP_RAM -- requirements
Module: byte_strobe_sdp_ram

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_WIDTH, 32: word width in bits; a power of two, at least 8.
- ADDR_WIDTH, 10: byte-address width.
- RD_LATENCY, 1: read latency in cycles; legal values 1 to 3.
- INIT_VALUE, 0: DATA_WIDTH-bit value written to every word after reset.
REQ-002 Derived values: NB = DATA_WIDTH/8; ADDR_LSB = clog2(NB); DEPTH = 2**(ADDR_WIDTH-ADDR_LSB) words.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic is on its rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- wr_en, in, 1: write request.
- wr_addr, in, ADDR_WIDTH: byte address; word index = wr_addr[ADDR_WIDTH-1:ADDR_LSB].
- wr_data, in, DATA_WIDTH: write data; byte i = wr_data[8i+7:8i].
- wr_strb, in, NB: byte enables.
- wr_ready, out, 1: the block accepts writes.
- rd_en, in, 1: read request.
- rd_addr, in, ADDR_WIDTH: byte address; word index as for wr_addr.
- rd_data, out, DATA_WIDTH: read data.
- rd_valid, out, 1: rd_data holds the result of an accepted read.
- init_done, out, 1: memory initialisation is complete.

Function
REQ-004 The block SHALL contain a two-state FSM: INIT and READY.
- INIT: a counter writes INIT_VALUE to word 0, word 1, and so on, one word per cycle.
- When the counter reaches DEPTH-1 and that word is written, the FSM SHALL go to READY on the next edge. The counter SHALL NOT wrap.
REQ-005 In READY, init_done and wr_ready SHALL be 1. In INIT, both SHALL be 0.
REQ-006 A write is accepted when wr_en=1 and wr_ready=1 at a rising edge.
- Only the bytes with wr_strb[i]=1 are updated, in that edge.
- The other bytes keep their old values; there is no read-modify-write cycle.
REQ-007 An accepted write with wr_strb=0 SHALL leave the memory unchanged.
REQ-008 wr_en in INIT SHALL be ignored. No write is queued for later.
REQ-009 A read is accepted when rd_en=1 and init_done=1 at edge t.
- rd_valid SHALL be 1 for exactly one cycle, after edge t+RD_LATENCY.
- rd_data SHALL carry the word from that read in the same cycle.
REQ-010 Reads SHALL be fully pipelined: one accepted read per cycle gives one rd_valid per cycle, in request order.
REQ-011 rd_data SHALL hold its last value while rd_valid=0.
REQ-012 rd_en in INIT SHALL be ignored and SHALL NOT produce rd_valid.
REQ-013 A write at edge t SHALL be visible to any read accepted at edge t+1 or later.
REQ-014 If a read and a write to the same word are accepted at the same edge, the result is set by REQ-020.
REQ-015 Reads and writes to different words in the same cycle SHALL NOT interact.
REQ-016 All address bits below ADDR_LSB SHALL be ignored.

Reset
REQ-017 While rst_n=0, all outputs SHALL be held at these values, independent of clk:
- wr_ready=0, init_done=0, rd_valid=0, rd_data=0.
- FSM in INIT, init counter at 0, all read-pipeline valid bits cleared.
REQ-018 Reset during READY or INIT SHALL discard in-flight reads. No rd_valid SHALL appear for them.
- After rst_n deasserts, the full INIT sequence SHALL restart from word 0.
REQ-019 The memory array SHALL have no reset. Its contents are defined only by the INIT sequence.

Configuration
REQ-020 The macro BYTE_STROBE_SDP_RAM_BYPASS_EN SHALL select same-word read/write collision behaviour.
- Defined: the read returns the merged word: new bytes where wr_strb=1, old bytes elsewhere (write-first).
- Undefined: the read returns the word before the write (read-first), and no bypass logic is built.

Verification
REQ-021 Bench parameters: DATA_WIDTH=32, ADDR_WIDTH=10 (DEPTH=256), RD_LATENCY=2, INIT_VALUE=32'hA5A5A5A5. The bench SHALL cover these scenarios:
- Reset release -> init_done rises after exactly 256 cycles; a read of byte address 0x3FC then returns 32'hA5A5A5A5 two cycles later.
- Write 0x11223344 to address 0x010 with strb 4'b0101, then read 0x010 -> 32'hA522A544; a read of 0x013 returns the same word.
- Reads to 0x000, 0x004, 0x008 on three back-to-back cycles -> three consecutive rd_valid pulses with data in request order.
- Same-edge write (0x010, 0xDEADBEEF, strb 4'b1111) and read (0x010) when the word holds 0x01020304 -> read returns 0xDEADBEEF with the macro defined, 0x01020304 without it.
- rst_n asserted one cycle after a read is accepted -> no rd_valid; outputs take their reset values at once; INIT restarts.
- wr_en and rd_en held high during INIT -> no rd_valid, and memory still reads INIT_VALUE after init.

Source files
------------

// File: rtl/byte_strobe_sdp_ram.sv
// Simple dual-port RAM with byte strobes, a self-initialising INIT sweep and a pipelined read path.
// Optional macro BYTE_STROBE_SDP_RAM_BYPASS_EN: same-word read/write returns the merged (write-first) word.
module byte_strobe_sdp_ram #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    wr_ready,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_done
);

  localparam int NB       = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(NB);
  localparam int WA       = ADDR_WIDTH - ADDR_LSB;
  localparam int DEPTH    = 1 << WA;
  localparam logic [WA-1:0] CNT_ONE  = {{(WA-1){1'b0}}, 1'b1};
  localparam logic [WA-1:0] CNT_LAST = {WA{1'b1}};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state_r;
  logic [WA-1:0]         init_cnt_r;
  logic                  ready_r;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  logic [WA-1:0]         wr_idx_s;
  logic [WA-1:0]         rd_idx_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic [NB-1:0]         mem_we_s;
  logic [WA-1:0]         mem_widx_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic [DATA_WIDTH-1:0] rd_old_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  logic [DATA_WIDTH-1:0] pipe_data_r [RD_LATENCY];
  logic [RD_LATENCY-1:0] pipe_vld_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;

  assign wr_idx_s = wr_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx_s = rd_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign wr_acc_s = wr_en & ready_r;
  assign rd_acc_s = rd_en & ready_r;

  // Sub-word address bits carry no meaning for a word-wide memory.
  generate
    if (ADDR_LSB > 0) begin : g_lsb
      logic unused_lsb_s;
      assign unused_lsb_s = ^{wr_addr[ADDR_LSB-1:0], rd_addr[ADDR_LSB-1:0]};
    end
  endgenerate

  // Init sweep FSM: one word per cycle, then parks in READY without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      init_cnt_r <= '0;
      ready_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if (init_cnt_r == CNT_LAST) begin
            state_r <= ST_READY;
            ready_r <= 1'b1;
          end else begin
            init_cnt_r <= init_cnt_r + CNT_ONE;
            ready_r    <= 1'b0;
          end
        end
        ST_READY: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r    <= ST_INIT;
          init_cnt_r <= '0;
          ready_r    <= 1'b0;
        end
      endcase
    end
  end

  // Select the single memory write port source: init sweep or user write.
  always_comb begin
    mem_we_s    = '0;
    mem_widx_s  = init_cnt_r;
    mem_wdata_s = INIT_VALUE;
    if (ready_r) begin
      mem_widx_s  = wr_idx_s;
      mem_wdata_s = wr_data;
      mem_we_s    = wr_acc_s ? wr_strb : '0;
    end else begin
      mem_we_s    = '1;
    end
  end

  // Byte-granular memory write; the array itself is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_we_s[i]) begin
        mem_r[mem_widx_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
      end
    end
  end

  assign rd_old_s = mem_r[rd_idx_s];

`ifdef BYTE_STROBE_SDP_RAM_BYPASS_EN
  logic hit_s;
  assign hit_s = wr_acc_s & (wr_idx_s == rd_idx_s);

  // Merge same-edge write bytes into the read word (write-first).
  always_comb begin
    rd_word_s = rd_old_s;
    for (int i = 0; i < NB; i++) begin
      rd_word_s[8*i +: 8] = (hit_s && wr_strb[i]) ? wr_data[8*i +: 8] : rd_old_s[8*i +: 8];
    end
  end
`else
  assign rd_word_s = rd_old_s;
`endif

  // Read pipeline: stage 0 captures at the accepting edge, later stages add latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld_r <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        pipe_data_r[k] <= '0;
      end
    end else begin
      pipe_vld_r[0]  <= rd_acc_s;
      pipe_data_r[0] <= rd_word_s;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_vld_r[k]  <= pipe_vld_r[k-1];
        pipe_data_r[k] <= pipe_data_r[k-1];
      end
    end
  end

  // Output register: data only changes with a valid result, otherwise it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= '0;
    end else begin
      rd_valid_r <= pipe_vld_r[RD_LATENCY-1];
      if (pipe_vld_r[RD_LATENCY-1]) begin
        rd_data_r <= pipe_data_r[RD_LATENCY-1];
      end
    end
  end

  assign wr_ready  = ready_r;
  assign init_done = ready_r;
  assign rd_valid  = rd_valid_r;
  assign rd_data   = rd_data_r;

endmodule

// File: tb/tb_byte_strobe_sdp_ram.sv
// Scoreboard bench for byte_strobe_sdp_ram: stimulus pushes expected reads, a negedge monitor checks them.
module tb_byte_strobe_sdp_ram;

  localparam int          DW   = 32;
  localparam int          AW   = 10;
  localparam int          LAT  = 2;
  localparam logic [31:0] INIT = 32'hA5A5A5A5;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_strb;
  logic          wr_ready;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          init_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_q [$];
  int          acc_q [$];

  byte_strobe_sdp_ram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_LATENCY (LAT),
    .INIT_VALUE (INIT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wr_ready  (wr_ready),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .init_done (init_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Monitor: every rd_valid pulse must match the oldest outstanding read, in data and latency.
  initial begin
    logic [31:0] e;
    int          a;
    forever begin
      @(negedge clk);
      if (rd_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rd_valid: got rd_valid=1 data=%h, required no pulse", rd_data);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          if (rd_data !== e) begin
            bad++;
            $display("FAIL rd_data: got %h, required %h", rd_data, e);
          end
          total++;
          if (cyc - a != LAT) begin
            bad++;
            $display("FAIL rd_latency: got %0d, required %0d", cyc - a, LAT);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (init_done) break;
    end
    chk("init_cycles", n, 32'd256);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] e);
    rd_en = 1'b1; rd_addr = a;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    acc_q.push_back(cyc);
    rd_en = 1'b0;
  endtask

  task automatic drain();
    repeat (LAT + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_en = 1'b0; rd_addr = '0;
    #23;
    chk_reset_outputs();

    // Requests held during INIT must be ignored.
    wr_en = 1'b1; wr_addr = 10'h3FC; wr_data = 32'h0; wr_strb = 4'hF;
    rd_en = 1'b1; rd_addr = 10'h3FC;
    @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("wr_ready_up", {31'd0, wr_ready}, 32'd1);

    rd(10'h3FC, INIT);
    rd(10'h000, INIT);
    drain();

    // Partial strobe write, unaligned read alias, zero-strobe write.
    wr(10'h010, 32'h11223344, 4'b0101);
    rd(10'h010, 32'hA522A544);
    rd(10'h013, 32'hA522A544);
    wr(10'h000, 32'h10000001, 4'hF);
    wr(10'h004, 32'h20000002, 4'hF);
    wr(10'h008, 32'h30000003, 4'hF);
    wr(10'h008, 32'hFFFFFFFF, 4'h0);
    rd(10'h000, 32'h10000001);
    rd(10'h004, 32'h20000002);
    rd(10'h008, 32'h30000003);
    drain();
    chk("rd_data_hold", rd_data, 32'h30000003);

    // Same-edge collision on one word.
    wr(10'h010, 32'h01020304, 4'hF);
    wr_en = 1'b1; wr_addr = 10'h010; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
    rd_en = 1'b1; rd_addr = 10'h010;
    @(posedge clk);
    #1;
`ifdef BYTE_STROBE_SDP_RAM_BYPASS_EN
    exp_q.push_back(32'hDEADBEEF);
`else
    exp_q.push_back(32'h01020304);
`endif
    acc_q.push_back(cyc);
    wr_en = 1'b0; rd_en = 1'b0;
    rd(10'h010, 32'hDEADBEEF);
    drain();

    // Reset one cycle after an accepted read: the read is dropped.
    rd_en = 1'b1; rd_addr = 10'h004;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init();
    rd(10'h010, INIT);
    rd(10'h004, INIT);
    drain();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
